// File: rtl/br_resolve_unit_if.sv
// Bundle of the IF->ID->EX handshake, the WB flush request and the predictor training/repair
// signals around br_resolve_unit.
//   master : stimulus side (drives instructions, out_ready, flush)
//   slave  : resolver side (drives in_ready, stage outputs, training, redirect, counters)
interface br_resolve_unit_if;
  // IF -> ID
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_pred_npc;
  logic [3:0]  in_br_op;
  logic [31:0] in_offs;
  logic [31:0] in_rj_val;
  logic [31:0] in_rd_val;
  // ID -> EX
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  // WB flush
  logic        flush;
  logic [31:0] flush_pc;
  // Predictor training / repair
  logic        br_taken;
  logic [31:0] current_pc;
  logic [31:0] br_target;
  logic        notice_pre;
  // Pre-IF redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Performance counters
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output in_valid, in_pc, in_pred_npc, in_br_op, in_offs, in_rj_val, in_rd_val,
    output out_ready, flush, flush_pc,
    input  in_ready, out_valid, out_pc,
    input  br_taken, current_pc, br_target, notice_pre,
    input  redirect_valid, redirect_pc, br_cnt, mispred_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_pred_npc, in_br_op, in_offs, in_rj_val, in_rd_val,
    input  out_ready, flush, flush_pc,
    output in_ready, out_valid, out_pc,
    output br_taken, current_pc, br_target, notice_pre,
    output redirect_valid, redirect_pc, br_cnt, mispred_cnt
  );
endinterface

// File: rtl/br_resolve_unit.sv
// Decode-stage branch resolver. Holds one instruction in a single-entry ID register, resolves its
// real next PC, trains/repairs the next-PC predictor, issues fetch redirects, drops wrong-path
// instructions by tracking the expected PC, and counts branches and mispredictions.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : br_resolve_unit_if.slave -- IF->ID input handshake, ID->EX output handshake, WB flush,
//          predictor training (br_taken/current_pc/br_target/notice_pre), redirect, counters
module br_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic              clk,
  input logic              rst,
  br_resolve_unit_if.slave bus
);

  localparam logic [3:0] OpBeq  = 4'd1;
  localparam logic [3:0] OpBne  = 4'd2;
  localparam logic [3:0] OpBlt  = 4'd3;
  localparam logic [3:0] OpBge  = 4'd4;
  localparam logic [3:0] OpBltu = 4'd5;
  localparam logic [3:0] OpBgeu = 4'd6;
  localparam logic [3:0] OpB    = 4'd7;
  localparam logic [3:0] OpBl   = 4'd8;
  localparam logic [3:0] OpJirl = 4'd9;

  // Stage register
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pred_npc_q, offs_q, rj_q, rd_q;
  logic [3:0]  op_q;

  logic [31:0] expect_pc_q, expect_pc_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic        fire, taken, is_br, mispred, load;
  logic [31:0] target, seq_pc, act_npc, cmp_pc;

  // Resolve the held instruction
  always_comb begin
    seq_pc = pc_q + 32'd4;
    target = (op_q == OpJirl) ? (rj_q + offs_q) : (pc_q + offs_q);
    taken  = 1'b0;
    case (op_q)
      OpBeq:            taken = (rj_q == rd_q);
      OpBne:            taken = (rj_q != rd_q);
      OpBlt:            taken = ($signed(rj_q) <  $signed(rd_q));
      OpBge:            taken = ($signed(rj_q) >= $signed(rd_q));
      OpBltu:           taken = (rj_q <  rd_q);
      OpBgeu:           taken = (rj_q >= rd_q);
      OpB, OpBl, OpJirl: taken = 1'b1;
      default:          taken = 1'b0;
    endcase
    is_br   = (op_q >= OpBeq) && (op_q <= OpJirl);
    act_npc = taken ? target : seq_pc;
  end

  assign fire    = valid_q & bus.out_ready & ~bus.flush;
  assign mispred = fire & (pred_npc_q != act_npc);

  assign bus.in_ready  = ~valid_q | bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_q;

  // Training and redirect data are zeroed outside a fire so the predictor only sees real events.
  assign bus.br_taken       = fire & taken;
  assign bus.notice_pre     = fire & ~taken & (pred_npc_q != seq_pc);
  assign bus.current_pc     = fire ? pc_q : 32'd0;
  assign bus.br_target      = fire ? target : 32'd0;
  assign bus.redirect_valid = mispred;
  assign bus.redirect_pc    = fire ? act_npc : 32'd0;
  assign bus.br_cnt         = br_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

  // A resolving instruction already knows the true next PC, so compare against it directly
  // to allow back-to-back issue without a bubble.
  assign cmp_pc = fire ? act_npc : expect_pc_q;
  assign load   = bus.in_valid & bus.in_ready & ~bus.flush & (bus.in_pc == cmp_pc);

  always_comb begin
    valid_d       = valid_q;
    expect_pc_d   = expect_pc_q;
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bus.flush) begin
      valid_d     = 1'b0;
      expect_pc_d = bus.flush_pc;
    end else begin
      if (fire) begin
        valid_d     = 1'b0;
        expect_pc_d = act_npc;
        if (is_br && (br_cnt_q != 32'hffffffff)) begin
          br_cnt_d = br_cnt_q + 32'd1;
        end
        if (mispred && (mispred_cnt_q != 32'hffffffff)) begin
          mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
      end
      if (load) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      expect_pc_q   <= RESET_PC;
      br_cnt_q      <= 32'd0;
      mispred_cnt_q <= 32'd0;
      pc_q          <= 32'd0;
      pred_npc_q    <= 32'd0;
      op_q          <= 4'd0;
      offs_q        <= 32'd0;
      rj_q          <= 32'd0;
      rd_q          <= 32'd0;
    end else begin
      valid_q       <= valid_d;
      expect_pc_q   <= expect_pc_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (load) begin
        pc_q       <= bus.in_pc;
        pred_npc_q <= bus.in_pred_npc;
        op_q       <= bus.in_br_op;
        offs_q     <= bus.in_offs;
        rj_q       <= bus.in_rj_val;
        rd_q       <= bus.in_rd_val;
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_unit.sv
module tb_br_resolve_unit;

  localparam logic [31:0] ResetPc = 32'h1c000000;

  logic clk;
  logic rst;

  br_resolve_unit_if bus ();

  br_resolve_unit #(.RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred;
    logic [3:0]  op;
    logic [31:0] offs;
    logic [31:0] rj;
    logic [31:0] rd;
  } instr_t;

  typedef struct {
    logic        in_valid;
    instr_t      ins;
    logic        flush;
    logic [31:0] flush_pc;
    logic        e_out_valid;
    logic        e_br_taken;
    logic        e_notice_pre;
    logic        e_redirect_valid;
    logic [31:0] e_redirect_pc;
    logic [31:0] e_br_target;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: the held instruction (0 or 1 entries), next expected PC, counters
  instr_t      m_q[$];
  logic [31:0] m_expect;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural branch semantics
  function automatic void resolve(input instr_t i, output logic tk, output logic [31:0] tg);
    tg = (i.op == 4'd9) ? i.rj + i.offs : i.pc + i.offs;
    case (i.op)
      4'd1: tk = (i.rj == i.rd);
      4'd2: tk = (i.rj != i.rd);
      4'd3: tk = ($signed(i.rj) < $signed(i.rd));
      4'd4: tk = !($signed(i.rj) < $signed(i.rd));
      4'd5: tk = (i.rj < i.rd);
      4'd6: tk = !(i.rj < i.rd);
      4'd7, 4'd8, 4'd9: tk = 1'b1;
      default: tk = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] real_npc(input instr_t i);
    logic tk;
    logic [31:0] tg;
    resolve(i, tk, tg);
    return tk ? tg : i.pc + 32'd4;
  endfunction

  // PC the DUT will accept this cycle given out_ready / flush
  function automatic logic [31:0] want_pc();
    if (m_q.size() != 0 && bus.out_ready && !bus.flush) return real_npc(m_q[0]);
    return m_expect;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_expect = ResetPc;
    m_br     = 32'd0;
    m_mis    = 32'd0;
  endtask

  task automatic drive(input logic v, input instr_t i);
    bus.in_valid    = v;
    bus.in_pc       = i.pc;
    bus.in_pred_npc = i.pred;
    bus.in_br_op    = i.op;
    bus.in_offs     = i.offs;
    bus.in_rj_val   = i.rj;
    bus.in_rd_val   = i.rd;
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] pred,
                                input logic [3:0] op, input logic [31:0] offs,
                                input logic [31:0] rj, input logic [31:0] rd);
    instr_t i;
    i.pc = pc; i.pred = pred; i.op = op; i.offs = offs; i.rj = rj; i.rd = rd;
    return i;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_br_taken", 32'(bus.br_taken), 32'd0);
    chk("rst_current_pc", bus.current_pc, 32'd0);
    chk("rst_br_target", bus.br_target, 32'd0);
    chk("rst_notice_pre", 32'(bus.notice_pre), 32'd0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_br_cnt", bus.br_cnt, 32'd0);
    chk("rst_mispred_cnt", bus.mispred_cnt, 32'd0);
  endtask

  // One clock: compare against the model, cross the edge, advance the model.
  // Called with inputs already driven just after a negedge.
  task automatic tick();
    logic        held, tk, fire, exp_ir;
    logic [31:0] tg, npc, cmp;
    instr_t      h;
    #1;
    held = (m_q.size() != 0);
    h    = held ? m_q[0] : '0;
    resolve(h, tk, tg);
    npc    = tk ? tg : h.pc + 32'd4;
    fire   = held && bus.out_ready && !bus.flush;
    exp_ir = !held || bus.out_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("out_valid", 32'(bus.out_valid), 32'(held));
    if (held) chk("out_pc", bus.out_pc, h.pc);
    chk("br_taken", 32'(bus.br_taken), 32'(fire && tk));
    chk("notice_pre", 32'(bus.notice_pre), 32'(fire && !tk && h.pred != h.pc + 32'd4));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(fire && h.pred != npc));
    chk("redirect_pc", bus.redirect_pc, fire ? npc : 32'd0);
    chk("current_pc", bus.current_pc, fire ? h.pc : 32'd0);
    chk("br_target", bus.br_target, fire ? tg : 32'd0);
    chk("br_cnt", bus.br_cnt, m_br);
    chk("mispred_cnt", bus.mispred_cnt, m_mis);
    @(posedge clk);
    if (bus.flush) begin
      m_q.delete();
      m_expect = bus.flush_pc;
    end else begin
      cmp = fire ? npc : m_expect;
      if (fire) begin
        if (h.op >= 4'd1 && h.op <= 4'd9 && m_br != 32'hffffffff) m_br = m_br + 1;
        if (h.pred != npc && m_mis != 32'hffffffff) m_mis = m_mis + 1;
        m_expect = npc;
        m_q.delete();
      end
      if (bus.in_valid && exp_ir && bus.in_pc == cmp)
        m_q.push_back(mk(bus.in_pc, bus.in_pred_npc, bus.in_br_op, bus.in_offs,
                         bus.in_rj_val, bus.in_rd_val));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[12];

  function automatic vec_t row(input logic v, input instr_t i, input logic fl,
                               input logic [31:0] fpc, input logic ov, input logic bt,
                               input logic np, input logic rv, input logic [31:0] rpc,
                               input logic [31:0] tg);
    vec_t r;
    r.in_valid = v; r.ins = i; r.flush = fl; r.flush_pc = fpc;
    r.e_out_valid = ov; r.e_br_taken = bt; r.e_notice_pre = np;
    r.e_redirect_valid = rv; r.e_redirect_pc = rpc; r.e_br_target = tg;
    return r;
  endfunction

  initial begin
    instr_t i0, hb;
    logic [31:0] r, pc;

    i0 = '0;
    drive(1'b0, i0);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.flush_pc  = 32'd0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Directed table: one row per cycle, out_ready held high
    vt[0]  = row(0, i0, 1, 32'h1c000010, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[1]  = row(1, mk(32'h1c000010, 32'h1c000014, 4'd1, 32'h40, 32'd5, 32'd5),
                 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[2]  = row(1, mk(32'h1c000050, 32'h1c000054, 4'd0, 32'h0, 32'd0, 32'd0),
                 0, 0, 1, 1, 0, 1, 32'h1c000050, 32'h1c000050);
    vt[3]  = row(0, i0, 0, 0, 1, 0, 0, 0, 32'h1c000054, 32'h1c000050);
    vt[4]  = row(0, i0, 1, 32'h1c000020, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[5]  = row(1, mk(32'h1c000020, 32'h1c000080, 4'd2, 32'h60, 32'd7, 32'd7),
                 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[6]  = row(1, mk(32'h1c000080, 32'h1c000084, 4'd0, 32'h0, 32'd0, 32'd0),
                 0, 0, 1, 0, 1, 1, 32'h1c000024, 32'h1c000080);
    vt[7]  = row(1, mk(32'h1c000024, 32'h1c000028, 4'd0, 32'h0, 32'd0, 32'd0),
                 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    vt[8]  = row(1, mk(32'h1c000028, 32'h1c00002c, 4'd3, 32'h100, 32'hffffffff, 32'd1),
                 0, 0, 1, 0, 0, 0, 32'h1c000028, 32'h1c000024);
    vt[9]  = row(1, mk(32'h1c000128, 32'h1c00012c, 4'd5, 32'h100, 32'hffffffff, 32'd1),
                 0, 0, 1, 1, 0, 1, 32'h1c000128, 32'h1c000128);
    vt[10] = row(1, mk(32'h1c00012c, 32'h1c001008, 4'd9, 32'h8, 32'h1c001000, 32'd0),
                 0, 0, 1, 0, 0, 0, 32'h1c00012c, 32'h1c000228);
    vt[11] = row(0, i0, 0, 0, 1, 1, 0, 0, 32'h1c001008, 32'h1c001008);

    for (int k = 0; k < 12; k++) begin
      drive(vt[k].in_valid, vt[k].ins);
      bus.flush    = vt[k].flush;
      bus.flush_pc = vt[k].flush_pc;
      #1;
      chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vt[k].e_out_valid));
      chk($sformatf("vec%0d_br_taken", k), 32'(bus.br_taken), 32'(vt[k].e_br_taken));
      chk($sformatf("vec%0d_notice_pre", k), 32'(bus.notice_pre), 32'(vt[k].e_notice_pre));
      chk($sformatf("vec%0d_redirect_valid", k), 32'(bus.redirect_valid),
          32'(vt[k].e_redirect_valid));
      chk($sformatf("vec%0d_redirect_pc", k), bus.redirect_pc, vt[k].e_redirect_pc);
      chk($sformatf("vec%0d_br_target", k), bus.br_target, vt[k].e_br_target);
      tick();
    end
    bus.flush = 1'b0;
    chk("dir_br_cnt", bus.br_cnt, 32'd5);
    chk("dir_mispred_cnt", bus.mispred_cnt, 32'd3);

    // Back-pressure: three stalled cycles, then a single resolve with back-to-back load
    drive(1'b1, mk(32'h1c001008, 32'h1c00100c, 4'd1, 32'h10, 32'd1, 32'd1));
    tick();
    hb = mk(32'h1c001018, 32'h1c00101c, 4'd7, 32'h20, 32'd0, 32'd0);
    drive(1'b1, hb);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_br_taken", 32'(bus.br_taken), 32'd0);
      chk("stall_redirect", 32'(bus.redirect_valid), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_br_taken", 32'(bus.br_taken), 32'd1);
    chk("unstall_redirect_pc", bus.redirect_pc, 32'h1c001018);
    tick();

    // Flush coincident with a taken branch that would otherwise fire
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h1c008000;
    drive(1'b1, mk(32'h1c001038, 32'h1c00103c, 4'd0, 32'h0, 32'd0, 32'd0));
    #1;
    chk("flush_held_pc", bus.out_pc, 32'h1c001018);
    chk("flush_br_taken", 32'(bus.br_taken), 32'd0);
    chk("flush_redirect", 32'(bus.redirect_valid), 32'd0);
    tick();
    bus.flush = 1'b0;
    tick();  // pc 1c001038 arrives after the flush and is dropped
    drive(1'b1, mk(32'h1c008000, 32'h1c008004, 4'd0, 32'h0, 32'd0, 32'd0));
    tick();
    drive(1'b0, i0);
    #1;
    chk("post_flush_out_pc", bus.out_pc, 32'h1c008000);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      bus.flush     = ($urandom_range(31) == 0);
      bus.flush_pc  = ResetPc + 32'($urandom_range(255) << 2);
      pc = ($urandom_range(3) != 0) ? want_pc() : (ResetPc + 32'($urandom_range(255) << 2));
      r = $urandom;
      i0.pc   = pc;
      i0.op   = 4'($urandom_range(15));
      i0.offs = {{22{r[9]}}, r[9:2], 2'b00};
      i0.rj   = pick_opnd();
      i0.rd   = ($urandom_range(2) == 0) ? i0.rj : pick_opnd();
      case ($urandom_range(2))
        0: i0.pred = pc + 32'd4;
        1: i0.pred = (i0.op == 4'd9) ? i0.rj + i0.offs : pc + i0.offs;
        default: i0.pred = $urandom;
      endcase
      drive(($urandom_range(3) != 0), i0);
      tick();
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    i0 = '0;
    drive(1'b0, i0);

    // Counter saturation
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h1c00a000;
    tick();
    bus.flush = 1'b0;
    force dut.mispred_cnt_q = 32'hffffffff;
    #1;
    release dut.mispred_cnt_q;
    m_mis = 32'hffffffff;
    drive(1'b1, mk(32'h1c00a000, 32'h1c00a004, 4'd7, 32'h40, 32'd0, 32'd0));
    tick();
    drive(1'b0, i0);
    #1;
    chk("sat_redirect", 32'(bus.redirect_valid), 32'd1);
    tick();
    chk("sat_mispred_cnt", bus.mispred_cnt, 32'hffffffff);

    // Async reset while an instruction is stalled
    drive(1'b1, mk(m_expect, m_expect + 32'd8, 4'd7, 32'h8, 32'd0, 32'd0));
    tick();
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, mk(ResetPc, ResetPc + 32'd4, 4'd7, 32'h10, 32'd0, 32'd0));
    tick();
    drive(1'b0, i0);
    tick();
    chk("post_rst_br_cnt", bus.br_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
